// File: rtl/dds_pkg.sv
// Shared definitions for the DDS datapath arithmetic blocks (Mult, seq_divider).
package dds_pkg;

    // Default operand width, shared with the 12-bit multiplier
    localparam int MULT_WIDTH = 12;

    // Sequential divider control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: 2m-bit dividend / m-bit divisor -> m-bit quotient
// and remainder, one quotient bit per clock, with a start/busy/done handshake.
// Divide-by-zero and quotient overflow are caught up front and reported
// through err one cycle after the accepted start.
module seq_divider
    import dds_pkg::*;
#(
    parameter int m = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*m-1:0]   dividend,
    input  logic [m-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [m-1:0]     quotient,
    output logic [m-1:0]     remainder
);

    localparam int CW = (m > 1) ? $clog2(m) : 1;

    div_state_t      state;
    div_state_t      state_next;

    logic [CW-1:0]   count;
    logic [m:0]      part;
    logic [m-1:0]    shift;
    logic [m-1:0]    dsr;

    logic            accept;
    logic            step;
    logic            last_step;
    logic            fault_in;

    logic [m:0]      trial;
    logic            take;
    logic [m:0]      diff;

    // A quotient that would not fit in m bits shows up as high half >= divisor;
    // a zero divisor is caught by the same comparison plus the explicit test.
    assign fault_in = (divisor == '0) || (dividend[2*m-1:m] >= divisor);

    // The shift register first holds the unconsumed low dividend bits (MSB
    // first) and fills with quotient bits from the bottom as they are produced.
    assign trial = {part[m-1:0], shift[m-1]};
    assign take  = (trial >= {1'b0, dsr});
    assign diff  = take ? (trial - {1'b0, dsr}) : trial;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: faults and results each occupy a single cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = fault_in ? FAULT : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                step      = 1'b1;
                last_step = (count == '0);
                busy      = 1'b1;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            part      <= '0;
            shift     <= '0;
            dsr       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                dsr   <= divisor;
                part  <= {1'b0, dividend[2*m-1:m]};
                shift <= dividend[m-1:0];
                count <= CW'(m - 1);
                err   <= 1'b0;
            end else if (step) begin
                part  <= diff;
                shift <= {shift[m-2:0], take};
                count <= count - 1'b1;
                if (last_step) begin
                    quotient  <= {shift[m-2:0], take};
                    remainder <= diff[m-1:0];
                    done      <= 1'b1;
                    err       <= 1'b0;
                end
            end else if (state == FAULT) begin
                quotient  <= '1;
                remainder <= shift;
                err       <= 1'b1;
                done      <= 1'b1;
            end
        end
    end

endmodule
